hazard_tracker: RTL and testbench
=================================

# hazard_tracker

Parametrised hazard-tracking pipeline for the five-stage MIPS core: carries each instruction's source/destination register numbers and remaining result latency (Tnew) through NSTAGE post-decode stages. Produces the D-stage stall request and forwarding-source selects for D-stage and E-stage readers. Replaces the fixed three-stage E/M/W register-tag chain: stage count, register-number width and Tnew width are generic, and Tnew counts down per stage instead of carrying a static result class.

## Interface
- NSTAGE, 3: post-D stages tracked (1 = E, 2 = M, ..., NSTAGE = W); legal 2..6
- REGW, 5: register-number width
- TW, 2: Tnew/Tuse width
- SELW, $clog2(NSTAGE+1): forwarding-select width (derived; not overridden)

Ports:
- clk  in  1  clock; single clock domain, rising edge
- reset  in  1  synchronous, active-high; clears all stage registers
- dval  in  1  D-stage instruction valid; 0 = D holds a bubble
- a1_d  in  REGW  rs number of D instruction
- a2_d  in  REGW  rt number of D instruction
- a3_d  in  REGW  destination number; 0 = no write
- tnew_d  in  TW  cycles after entering stage 1 until the result is forwardable
- tuse_rs_d  in  TW  cycles until D instruction needs rs (0 = needed in D)
- tuse_rt_d  in  TW  same for rt
- use_rs_d, use_rt_d  in  1 each  D instruction reads rs / rt
- stall_ext  in  1  external stall (mult/div busy)
- flush  in  1  kill D instruction (insert bubble into stage 1)
- stall  out  1  D/F hold request (combinational)
- fwd_rs_d, fwd_rt_d  out  SELW  forwarding source for D readers: 0 = GRF, s = stage s
- fwd_rs_e, fwd_rt_e  out  SELW  forwarding source for stage-1 readers: 0 = stage-1 register value, s in 2..NSTAGE
- a1_e, a2_e, a3_e  out  REGW  stage-1 tags (for mult/div and exception logic)

## Operation
- Each stage s holds {a1, a2, a3, tnew}. Bubble = all fields 0.
- Match: stage s matches reader register r iff r != 0 and a3_s == r. Only the youngest (lowest s) match counts; older matches are shadowed.
- Hazard (rs): dval && use_rs_d && youngest match s exists && tnew_s > tuse_rs_d. Same rule for rt.
- stall = hazard_rs | hazard_rt | stall_ext.
- fwd_rs_d = youngest matching s if tnew_s == 0, else 0. Same rule for rt. Stage NSTAGE is a legal source (W→D bypass).
- fwd_rs_e: youngest s in 2..NSTAGE with a3_s == a1_e != 0 and tnew_s == 0, else 0. Same rule for rt using a2_e. A youngest match with tnew_s > 0 here is a design error: never produced when stall is honoured, and the bench asserts it.
- Advance each cycle: stage s+1 ← stage s with tnew' = (tnew == 0) ? 0 : tnew − 1 (saturating; no wrap).
- Stage 1 load: bubble if reset | flush | stall | !dval; else {a1_d, a2_d, a3_d, tnew_d}. Stages 2..NSTAGE always advance; stall never freezes them.
- Priority: reset > flush > stall > load.

## Timing
- Reset: all stage registers 0 one edge after reset is sampled high. stall = stall_ext only. All fwd_* = 0. a1_e/a2_e/a3_e = 0.
- stall and fwd_* are same-cycle combinational from the D inputs and the stage registers. There is no registered output path other than a*_e.
- Producer with tnew_d = t: forwardable from stage t+1 onward; it is visible in stage s for the cycle s−1 edges after D issue.
- A hazard stall lasts exactly tnew_s − tuse cycles, absent stall_ext. The pipeline below D drains one stage per cycle during the stall.
- Reset mid-stall: stall drops to stall_ext on the cycle after the reset edge.

## Test plan
- Reset → after one edge a3_e = 0, stall = 0, all fwd = 0. Also, with stall_ext = 1 and dval = 0: stall = 1, a3_e = 0.
- ALU back-to-back: issue a3_d = 8, tnew_d = 1; next D a1_d = 8, tuse_rs_d = 1. Required: stall = 0, fwd_rs_d = 0. Next cycle fwd_rs_e = 2.
- Load-use: a3_d = 9, tnew_d = 2; next D reads rs = 9 with tuse = 0. Required: stall = 1 for 2 cycles, then fwd_rs_d = 3 (NSTAGE = 3).
- Shadowing: stage 2 a3 = 5, tnew = 0 and stage 1 a3 = 5, tnew = 1; D reads rt = 5, tuse = 0. Required: stall = 1, not forward from stage 2.
- $zero: a3_d = 0, tnew_d = 2; next D reads rs = 0. Required: stall = 0, fwd_rs_d = 0.
- NSTAGE = 5, flush with a valid D instruction: stage 1 = bubble. tnew saturates at 0 through stage 5 (no wrap to 3).

Source files
------------

// File: rtl/hazard_tracker_if.sv
// D-stage request and hazard/forwarding response bundle for hazard_tracker.
// SELW is derived from NSTAGE here so both sides agree on select width.
interface hazard_tracker_if #(
  parameter int NSTAGE = 3,
  parameter int REGW   = 5,
  parameter int TW     = 2
);
  localparam int SELW = $clog2(NSTAGE + 1);

  logic            dval;
  logic [REGW-1:0] a1_d;
  logic [REGW-1:0] a2_d;
  logic [REGW-1:0] a3_d;
  logic [TW-1:0]   tnew_d;
  logic [TW-1:0]   tuse_rs_d;
  logic [TW-1:0]   tuse_rt_d;
  logic            use_rs_d;
  logic            use_rt_d;
  logic            stall_ext;
  logic            flush;

  logic            stall;
  logic [SELW-1:0] fwd_rs_d;
  logic [SELW-1:0] fwd_rt_d;
  logic [SELW-1:0] fwd_rs_e;
  logic [SELW-1:0] fwd_rt_e;
  logic [REGW-1:0] a1_e;
  logic [REGW-1:0] a2_e;
  logic [REGW-1:0] a3_e;

  modport master (
    output dval, a1_d, a2_d, a3_d, tnew_d, tuse_rs_d, tuse_rt_d,
           use_rs_d, use_rt_d, stall_ext, flush,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, a1_e, a2_e, a3_e
  );

  modport slave (
    input  dval, a1_d, a2_d, a3_d, tnew_d, tuse_rs_d, tuse_rt_d,
           use_rs_d, use_rt_d, stall_ext, flush,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, a1_e, a2_e, a3_e
  );
endinterface

// File: rtl/hazard_tracker.sv
// Register-tag pipeline behind D: per-stage {a1,a2,a3,tnew}, youngest-match
// hazard detection, and D/E forwarding selects. Tnew counts down per stage.
module hazard_tracker #(
  parameter int NSTAGE = 3,
  parameter int REGW   = 5,
  parameter int TW     = 2
) (
  input  logic           clk,
  input  logic           reset,
  hazard_tracker_if.slave hif
);
  localparam int SELW = $clog2(NSTAGE + 1);

  typedef struct packed {
    logic [REGW-1:0] a1;
    logic [REGW-1:0] a2;
    logic [REGW-1:0] a3;
    logic [TW-1:0]   tnew;
  } stage_t;

  typedef stage_t [NSTAGE:1] stage_arr_t;

  typedef struct packed {
    logic            hit;
    logic [SELW-1:0] sel;
    logic [TW-1:0]   tnew;
  } match_t;

  stage_arr_t stg_q, stg_d;

  // Scan oldest to youngest so the lowest matching stage overwrites the rest.
  function automatic match_t youngest(input stage_arr_t st,
                                      input logic [REGW-1:0] r,
                                      input int lo);
    match_t m;
    m = '0;
    for (int s = NSTAGE; s >= 1; s--) begin
      if (s >= lo && r != '0 && st[s].a3 == r) begin
        m.hit  = 1'b1;
        m.sel  = SELW'(s);
        m.tnew = st[s].tnew;
      end
    end
    return m;
  endfunction

  function automatic logic [SELW-1:0] fwd_sel(input match_t m);
    return (m.hit && m.tnew == '0) ? m.sel : '0;
  endfunction

  match_t m_rs_d, m_rt_d, m_rs_e, m_rt_e;
  logic   haz_rs, haz_rt, stall;

  always_comb begin
    m_rs_d = youngest(stg_q, hif.a1_d, 1);
    m_rt_d = youngest(stg_q, hif.a2_d, 1);
    m_rs_e = youngest(stg_q, stg_q[1].a1, 2);
    m_rt_e = youngest(stg_q, stg_q[1].a2, 2);
    haz_rs = hif.dval && hif.use_rs_d && m_rs_d.hit && (m_rs_d.tnew > hif.tuse_rs_d);
    haz_rt = hif.dval && hif.use_rt_d && m_rt_d.hit && (m_rt_d.tnew > hif.tuse_rt_d);
    stall  = haz_rs | haz_rt | hif.stall_ext;
  end

  assign hif.stall    = stall;
  assign hif.fwd_rs_d = fwd_sel(m_rs_d);
  assign hif.fwd_rt_d = fwd_sel(m_rt_d);
  assign hif.fwd_rs_e = fwd_sel(m_rs_e);
  assign hif.fwd_rt_e = fwd_sel(m_rt_e);
  assign hif.a1_e     = stg_q[1].a1;
  assign hif.a2_e     = stg_q[1].a2;
  assign hif.a3_e     = stg_q[1].a3;

  // Stages 2..NSTAGE always advance; only stage 1 sees flush/stall bubbles.
  always_comb begin
    stg_d = '0;
    if (hif.dval && !hif.flush && !stall) begin
      stg_d[1].a1   = hif.a1_d;
      stg_d[1].a2   = hif.a2_d;
      stg_d[1].a3   = hif.a3_d;
      stg_d[1].tnew = hif.tnew_d;
    end
    for (int s = 2; s <= NSTAGE; s++) begin
      stg_d[s] = stg_q[s-1];
      if (stg_q[s-1].tnew != '0)
        stg_d[s].tnew = stg_q[s-1].tnew - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stg_q <= '0;
    else       stg_q <= stg_d;
  end
endmodule

// File: tb/tb_hazard_tracker.sv
// Table-driven bench for hazard_tracker (NSTAGE=3 and NSTAGE=5 instances);
// expected outputs are queued as each row is driven and popped when sampled.
module tb_hazard_tracker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3, rst5;

  hazard_tracker_if #(.NSTAGE(3), .REGW(5), .TW(2)) if3();
  hazard_tracker_if #(.NSTAGE(5), .REGW(5), .TW(2)) if5();

  hazard_tracker #(.NSTAGE(3), .REGW(5), .TW(2)) u3 (.clk(clk), .reset(rst3), .hif(if3.slave));
  hazard_tracker #(.NSTAGE(5), .REGW(5), .TW(2)) u5 (.clk(clk), .reset(rst5), .hif(if5.slave));

  typedef struct {
    logic       rst, dval;
    logic [4:0] a1, a2, a3;
    logic [1:0] tn, tur, tut;
    logic       urs, urt, sx, fl;
    logic       st;
    logic [2:0] frd, ftd, fre, fte;
    logic [4:0] a3e;
  } vec_t;

  typedef struct {
    int         dut;
    int         row;
    logic       st;
    logic [2:0] frd, ftd, fre, fte;
    logic [4:0] a3e;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  vec_t t3[21];
  vec_t t5[8];

  function automatic vec_t v(input int rst, dval, a1, a2, a3, tn, tur, tut,
                             input int urs, urt, sx, fl,
                             input int st, frd, ftd, fre, fte, a3e);
    vec_t x;
    x.rst = 1'(rst); x.dval = 1'(dval);
    x.a1 = 5'(a1); x.a2 = 5'(a2); x.a3 = 5'(a3);
    x.tn = 2'(tn); x.tur = 2'(tur); x.tut = 2'(tut);
    x.urs = 1'(urs); x.urt = 1'(urt); x.sx = 1'(sx); x.fl = 1'(fl);
    x.st = 1'(st); x.frd = 3'(frd); x.ftd = 3'(ftd); x.fre = 3'(fre); x.fte = 3'(fte);
    x.a3e = 5'(a3e);
    return x;
  endfunction

  task automatic chk(input string nm, input int dut, input int row,
                     input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL n%0d row %0d %s: got %0d expected %0d", dut, row, nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic apply(input int dut, input int row, input vec_t x);
    exp_t e, g;
    @(posedge clk); #1;
    if (dut == 3) begin
      rst3 = x.rst; if3.dval = x.dval;
      if3.a1_d = x.a1; if3.a2_d = x.a2; if3.a3_d = x.a3; if3.tnew_d = x.tn;
      if3.tuse_rs_d = x.tur; if3.tuse_rt_d = x.tut;
      if3.use_rs_d = x.urs; if3.use_rt_d = x.urt;
      if3.stall_ext = x.sx; if3.flush = x.fl;
    end else begin
      rst5 = x.rst; if5.dval = x.dval;
      if5.a1_d = x.a1; if5.a2_d = x.a2; if5.a3_d = x.a3; if5.tnew_d = x.tn;
      if5.tuse_rs_d = x.tur; if5.tuse_rt_d = x.tut;
      if5.use_rs_d = x.urs; if5.use_rt_d = x.urt;
      if5.stall_ext = x.sx; if5.flush = x.fl;
    end
    e.dut = dut; e.row = row; e.st = x.st;
    e.frd = x.frd; e.ftd = x.ftd; e.fre = x.fre; e.fte = x.fte; e.a3e = x.a3e;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_tot++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      g = sb.pop_front();
      if (g.dut == 3) begin
        chk("stall",    3, g.row, 8'(if3.stall),    8'(g.st));
        chk("fwd_rs_d", 3, g.row, 8'(if3.fwd_rs_d), 8'(g.frd));
        chk("fwd_rt_d", 3, g.row, 8'(if3.fwd_rt_d), 8'(g.ftd));
        chk("fwd_rs_e", 3, g.row, 8'(if3.fwd_rs_e), 8'(g.fre));
        chk("fwd_rt_e", 3, g.row, 8'(if3.fwd_rt_e), 8'(g.fte));
        chk("a3_e",     3, g.row, 8'(if3.a3_e),     8'(g.a3e));
      end else begin
        chk("stall",    5, g.row, 8'(if5.stall),    8'(g.st));
        chk("fwd_rs_d", 5, g.row, 8'(if5.fwd_rs_d), 8'(g.frd));
        chk("fwd_rt_d", 5, g.row, 8'(if5.fwd_rt_d), 8'(g.ftd));
        chk("fwd_rs_e", 5, g.row, 8'(if5.fwd_rs_e), 8'(g.fre));
        chk("fwd_rt_e", 5, g.row, 8'(if5.fwd_rt_e), 8'(g.fte));
        chk("a3_e",     5, g.row, 8'(if5.a3_e),     8'(g.a3e));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    //            rst dv a1 a2 a3 tn tur tut urs urt sx fl | st frd ftd fre fte a3e
    t3[0]  = v(1, 1, 3, 4, 8, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);  // in reset
    t3[1]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0);  // stall_ext only
    t3[2]  = v(0, 1, 1, 2, 8, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // ALU producer r8
    t3[3]  = v(0, 1, 8, 0,10, 1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 8);  // back-to-back reader
    t3[4]  = v(0, 1, 0, 0, 9, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0,10);  // load r9; E fwd from 2
    t3[5]  = v(0, 1, 9, 8,11, 1, 0, 0, 1, 1, 0, 0,  1, 0, 3, 0, 0, 9);  // load-use stall 1
    t3[6]  = v(0, 1, 9, 8,11, 1, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0);  // stall 2
    t3[7]  = v(0, 1, 9, 8,11, 1, 0, 0, 1, 1, 0, 0,  0, 3, 0, 0, 0, 0);  // W->D bypass
    t3[8]  = v(0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,11);  // write to $zero
    t3[9]  = v(0, 1, 0,11, 0, 0, 0, 0, 1, 1, 0, 0,  0, 0, 2, 0, 0, 0);  // read $zero, r11
    t3[10] = v(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3, 0);  // producer A r5
    t3[11] = v(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 5);  // producer B r5
    t3[12] = v(0, 1, 0, 5,12, 0, 0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 5);  // shadowed by B
    t3[13] = v(0, 1, 0, 5,12, 0, 0, 0, 0, 1, 0, 0,  0, 0, 2, 0, 0, 0);  // B forwards
    t3[14] = v(0, 1, 0, 0,13, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 3,12);  // flush
    t3[15] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    t3[16] = v(0, 1, 0, 0,14, 1, 0, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0);  // ext stall w/ valid
    t3[17] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    t3[18] = v(0, 1, 0, 0, 9, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // tnew 3 producer
    t3[19] = v(1, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0, 9);  // reset mid-stall
    t3[20] = v(0, 1, 9, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    t5[0]  = v(0, 1, 0, 0,13, 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);  // flush valid D
    t5[1]  = v(0, 1, 0, 0, 7, 3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);  // r7 tnew 3
    t5[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 7);
    t5[3]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    t5[4]  = v(0, 1, 7, 7, 0, 0, 0, 0, 1, 1, 0, 0,  1, 0, 0, 0, 0, 0);  // r7 in stage 3, tnew 1
    t5[5]  = v(0, 1, 7, 7, 0, 0, 0, 0, 1, 1, 0, 0,  0, 4, 4, 0, 0, 0);
    t5[6]  = v(0, 1, 7, 7, 0, 0, 0, 0, 1, 1, 0, 0,  0, 5, 5, 5, 5, 0);  // saturated in stage 5
    t5[7]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    rst3 = 1'b1; rst5 = 1'b1;
    if3.dval = 0; if3.a1_d = 0; if3.a2_d = 0; if3.a3_d = 0; if3.tnew_d = 0;
    if3.tuse_rs_d = 0; if3.tuse_rt_d = 0; if3.use_rs_d = 0; if3.use_rt_d = 0;
    if3.stall_ext = 0; if3.flush = 0;
    if5.dval = 0; if5.a1_d = 0; if5.a2_d = 0; if5.a3_d = 0; if5.tnew_d = 0;
    if5.tuse_rs_d = 0; if5.tuse_rt_d = 0; if5.use_rs_d = 0; if5.use_rt_d = 0;
    if5.stall_ext = 0; if5.flush = 0;
    repeat (2) @(posedge clk);
    #1 rst5 = 1'b0;

    for (int i = 0; i < 21; i++) apply(3, i, t3[i]);
    for (int i = 0; i < 8; i++)  apply(5, i, t5[i]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
